// File: rtl/push_arbiter.sv
// push_arbiter: round-robin arbiter that funnels 4-phase push requests from
// PORT_COUNT ports into one shared FIFO write port.
//
// Ports:
//   clk, reset       - clock (rising edge) and asynchronous active-high reset
//   fifo_push_req    - per-port request, bit i belongs to port i
//   fifo_push_ack    - per-port acknowledge, one-hot or zero
//   fifo_push_data   - port i flit in [SIZE*(i+1)-1 : SIZE*i]
//   fifo_write       - one-cycle write strobe into the FIFO
//   fifo_full        - FIFO cannot accept a write this cycle
//   fifo_item_in     - flit presented to the FIFO, valid with fifo_write
//   grant            - index of the port being served, valid with busy
//   busy             - handshake in progress
module push_arbiter #(
    parameter int ID         = -1,
    parameter int SIZE       = 8,
    parameter int PORT_COUNT = 5,
    parameter int PORT_BITS  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORT_COUNT-1:0]      fifo_push_req,
    output logic [PORT_COUNT-1:0]      fifo_push_ack,
    input  logic [PORT_COUNT*SIZE-1:0] fifo_push_data,
    output logic                       fifo_write,
    input  logic                       fifo_full,
    output logic [SIZE-1:0]            fifo_item_in,
    output logic [PORT_BITS-1:0]       grant,
    output logic                       busy
);

    if ((1 << PORT_BITS) < PORT_COUNT) begin : g_bad_params
        $error("push_arbiter %0d: PORT_BITS too small for PORT_COUNT", ID);
    end

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [PORT_BITS-1:0]    ptr_q, ptr_d;
    logic [PORT_BITS-1:0]    grant_q, grant_d;
    logic [PORT_COUNT-1:0]   ack_q, ack_d;
    logic                    write_q, write_d;
    logic [SIZE-1:0]         item_q, item_d;

    logic                    win_valid;
    logic [PORT_BITS-1:0]    win_idx;
    logic [SIZE-1:0]         win_data;
    int                      p;

    // Search ptr, ptr+1, ... modulo PORT_COUNT. Walking the offsets from
    // high to low lets the nearest requester overwrite farther ones.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        p         = 0;
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            p = int'(ptr_q) + k;
            if (p >= PORT_COUNT) p = p - PORT_COUNT;
            if (fifo_push_req[p]) begin
                win_valid = 1'b1;
                win_idx   = PORT_BITS'(p);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (win_idx == PORT_BITS'(i)) win_data = fifo_push_data[i*SIZE +: SIZE];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        item_d  = item_q;
        write_d = 1'b0;       // strobe is a single-cycle pulse by construction
        case (state_q)
            IDLE: begin
                if (win_valid && !fifo_full) begin
                    grant_d          = win_idx;
                    item_d           = win_data;
                    write_d          = 1'b1;
                    ack_d            = '0;
                    ack_d[win_idx]   = 1'b1;
                    state_d          = ACK;
                end
            end
            ACK: begin
                // Only the granted port's req matters here; fifo_full is
                // irrelevant because the write has already gone out.
                if (!fifo_push_req[grant_q]) begin
                    ack_d   = '0;
                    ptr_d   = (grant_q == PORT_BITS'(PORT_COUNT - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            write_q <= 1'b0;
            item_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            write_q <= write_d;
            item_q  <= item_d;
        end
    end

    assign fifo_push_ack = ack_q;
    assign fifo_write    = write_q;
    assign fifo_item_in  = item_q;
    assign grant         = grant_q;
    assign busy          = (state_q == ACK);

endmodule

// File: tb/tb_push_arbiter.sv
module tb_push_arbiter;
    localparam int P  = 5;
    localparam int S  = 8;
    localparam int PB = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [P-1:0]   req = '0;
    logic [P-1:0]   ack;
    logic [P*S-1:0] pdata;
    logic           wr;
    logic           full = 1'b0;
    logic [S-1:0]   item;
    logic [PB-1:0]  grant;
    logic           busy;
    logic [S-1:0]   data [P];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain integers describing the handshake rules.
    int m_busy, m_ptr, m_grant, m_item, m_write;

    always #5 clk = ~clk;

    always_comb begin
        pdata = '0;
        for (int i = 0; i < P; i++) pdata[i*S +: S] = data[i];
    end

    push_arbiter #(.ID(0), .SIZE(S), .PORT_COUNT(P), .PORT_BITS(PB)) dut (
        .clk(clk), .reset(reset),
        .fifo_push_req(req), .fifo_push_ack(ack), .fifo_push_data(pdata),
        .fifo_write(wr), .fifo_full(full), .fifo_item_in(item),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_ptr = 0; m_grant = 0; m_item = 0; m_write = 0;
    endtask

    // Advance the model by one edge using the inputs the DUT will sample.
    task automatic m_step();
        m_write = 0;
        if (m_busy == 0) begin
            if (req != 0 && !full) begin
                for (int k = 0; k < P; k++) begin
                    if (req[(m_ptr + k) % P]) begin
                        m_grant = (m_ptr + k) % P;
                        break;
                    end
                end
                m_item  = data[m_grant];
                m_write = 1;
                m_busy  = 1;
            end
        end else if (!req[m_grant]) begin
            m_busy = 0;
            m_ptr  = (m_grant + 1) % P;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".write"}, 32'(wr), 32'(m_write));
        chk({tag, ".item"},  32'(item), 32'(m_item));
        chk({tag, ".ack"},   32'(ack), m_busy != 0 ? (32'd1 << m_grant) : 32'd0);
        chk({tag, ".busy"},  32'(busy), 32'(m_busy));
        chk({tag, ".grant"}, 32'(grant), 32'(m_grant));
        chk({tag, ".onehot"}, 32'($onehot0(ack)), 32'd1);
    endtask

    task automatic tick(input string tag);
        m_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int          nw;
        logic [7:0]  order [$];
        for (int i = 0; i < P; i++) data[i] = 8'h00;
        m_reset();
        #2;
        check_all("reset0");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single request from port 2.
        data[2] = 8'hA5;
        req     = 5'b00100;
        tick("single");
        chk("single.item_const", 32'(item), 32'hA5);
        chk("single.grant_const", 32'(grant), 32'd2);
        chk("single.ack_const", 32'(ack), 32'b00100);
        req = '0;
        tick("single_drop");
        chk("single.ptr", 32'(m_ptr), 32'd3);

        // All ports, rotating order with wrap.
        do_reset();
        for (int i = 0; i < P; i++) data[i] = 8'(8'h10 + i);
        req = '1;
        for (int c = 0; c < 100 && order.size() < 6; c++) begin
            tick("rr");
            if (wr) order.push_back(item);
            for (int i = 0; i < P; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i]) req[i] = 1'b1;
            end
        end
        chk("rr.count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk($sformatf("rr.order%0d", i), 32'(order[i]), 32'(8'h10 + (i % P)));
        req = '0;
        tick("rr_end");
        tick("rr_end2");

        // FIFO full blocks arbitration.
        do_reset();
        full = 1'b1;
        req  = 5'b00001;
        for (int c = 0; c < 10; c++) tick("full");
        full = 1'b0;
        tick("full_release");
        chk("full.write_const", 32'(wr), 32'd1);
        chk("full.ack_const", 32'(ack), 32'b00001);
        req = '0;
        tick("full_drop");

        // Held request produces exactly one write.
        data[1] = 8'h5C;
        req = 5'b00010;
        nw  = 0;
        for (int c = 0; c < 9; c++) begin
            tick("hold");
            if (wr) nw++;
        end
        chk("hold.writes", 32'(nw), 32'd1);
        chk("hold.ack_const", 32'(ack), 32'b00010);
        req = '0;
        tick("hold_drop");

        // Reset aborts a handshake on port 3.
        do_reset();
        data[3] = 8'h3E;
        data[4] = 8'h4F;
        req = 5'b01000;
        tick("rst_grant");
        chk("rst.grant_const", 32'(grant), 32'd3);
        tick("rst_busy");
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check_all("rst_async");
        #1;
        reset = 1'b0;
        req = 5'b11000;   // ptr restarts at 0, so port 3 wins over 4
        tick("rst_rearb");
        chk("rst.item_const", 32'(item), 32'h3E);
        req = '0;
        tick("rst_drop");

        // Random 4-phase traffic.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < P; i++) begin
                if (req[i]) begin
                    if (ack[i] && $urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else if (!ack[i] && $urandom_range(0, 3) == 0) begin
                    data[i] = 8'($urandom);
                    req[i]  = 1'b1;
                end
            end
            full = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
